// File: rtl/debounce_sync.sv
// debounce_sync: synchronises a raw asynchronous level, then accepts a new
// level only after it has held for STABLE_CYCLES consecutive clocks.
// Emits registered one-cycle RISE/FALL strobes and a BUSY qualifier flag.
// Optional feature: define DEBOUNCE_EVENT_CNT_EN to add EVENT_CNT[7:0],
// a wrapping count of accepted rising edges.
module debounce_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_WIDTH     = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       D_IN,
  output logic       Q,
  output logic       RISE,
  output logic       FALL,
`ifdef DEBOUNCE_EVENT_CNT_EN
  output logic [7:0] EVENT_CNT,
`endif
  output logic       BUSY
);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_CHECKING = 1'b1
  } state_t;

  // Count value on which the final qualifying cycle is seen (counter + 1 == STABLE_CYCLES).
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam bit                   SINGLE_CYCLE = (STABLE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  state_t                 state_r;
  logic [CNT_WIDTH-1:0]   cnt_r;
  logic                   q_r;
  logic                   rise_r;
  logic                   fall_r;
  logic                   busy_r;

  // Plain flop chain into the clock domain; no logic between stages.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], D_IN};
    end
  end

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Qualification FSM: counts consecutive cycles where the synchronised level differs from Q.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_STABLE;
      cnt_r   <= '0;
      q_r     <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      case (state_r)
        ST_STABLE: begin
          if (sync_s != q_r) begin
            if (SINGLE_CYCLE) begin
              q_r     <= sync_s;
              rise_r  <= sync_s;
              fall_r  <= ~sync_s;
              cnt_r   <= '0;
              state_r <= ST_STABLE;
              busy_r  <= 1'b0;
            end else begin
              cnt_r   <= CNT_ONE;
              state_r <= ST_CHECKING;
              busy_r  <= 1'b1;
            end
          end else begin
            cnt_r   <= '0;
            state_r <= ST_STABLE;
            busy_r  <= 1'b0;
          end
        end
        ST_CHECKING: begin
          if (sync_s == q_r) begin
            // Bounced back to the current level: abandon this candidate.
            cnt_r   <= '0;
            state_r <= ST_STABLE;
            busy_r  <= 1'b0;
          end else if (cnt_r == LAST_CNT) begin
            q_r     <= sync_s;
            rise_r  <= sync_s;
            fall_r  <= ~sync_s;
            cnt_r   <= '0;
            state_r <= ST_STABLE;
            busy_r  <= 1'b0;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
            state_r <= ST_CHECKING;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          cnt_r   <= '0;
          state_r <= ST_STABLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign Q    = q_r;
  assign RISE = rise_r;
  assign FALL = fall_r;
  assign BUSY = busy_r;

`ifdef DEBOUNCE_EVENT_CNT_EN
  logic [7:0] event_cnt_r;

  // Count accepted rising edges; updates on the edge after the RISE strobe, wraps naturally.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      event_cnt_r <= 8'd0;
    end else if (rise_r) begin
      event_cnt_r <= event_cnt_r + 8'd1;
    end else begin
      event_cnt_r <= event_cnt_r;
    end
  end

  assign EVENT_CNT = event_cnt_r;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync (SYNC_STAGES=2, STABLE_CYCLES=4).
// Expected outputs are predicted per clock, queued when D_IN is driven and
// popped when the DUT outputs are sampled on the falling edge.
module tb_debounce_sync;

  localparam int STAGES = 2;
  localparam int STABLE = 4;

  logic CLK = 1'b0;
  logic RST;
  logic D_IN;
  logic Q;
  logic RISE;
  logic FALL;
  logic BUSY;
`ifdef DEBOUNCE_EVENT_CNT_EN
  logic [7:0] EVENT_CNT;
`endif

  debounce_sync #(
    .SYNC_STAGES  (STAGES),
    .STABLE_CYCLES(STABLE),
    .CNT_WIDTH    (16)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .D_IN     (D_IN),
    .Q        (Q),
    .RISE     (RISE),
    .FALL     (FALL),
`ifdef DEBOUNCE_EVENT_CNT_EN
    .EVENT_CNT(EVENT_CNT),
`endif
    .BUSY     (BUSY)
  );

  // 10 ns clock
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic q;
    logic rise;
    logic fall;
    logic busy;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   rise_total = 0;
  exp_t exp_q[$];

  logic [STAGES-1:0] m_sync;
  logic              m_q;
  int                m_run;

  int          qe;
  int          rt0;
  logic [31:0] rm;
  logic [31:0] fm;
  logic [31:0] bm;
  exp_t        o;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sync = '0;
    m_q    = 1'b0;
    m_run  = 0;
  endtask

  // Drive one D_IN value for one clock, predict the outputs after that edge, compare.
  task automatic cycle(input logic din, output exp_t obs);
    exp_t e;
    logic s;
    D_IN = din;
    e    = '0;
    s    = m_sync[STAGES-1];
    if (s != m_q) begin
      m_run++;
      if (m_run == STABLE) begin
        m_q    = s;
        e.rise = s;
        e.fall = ~s;
        m_run  = 0;
      end
    end else begin
      m_run = 0;
    end
    e.q    = m_q;
    e.busy = (m_run != 0);
    m_sync = {m_sync[STAGES-2:0], din};
    exp_q.push_back(e);
    @(posedge CLK);
    @(negedge CLK);
    obs = {Q, RISE, FALL, BUSY};
    e   = exp_q.pop_front();
    check_eq("scoreboard", 32'(obs), 32'(e));
    if (RISE) rise_total++;
  endtask

  // Hold D_IN for n edges; report first edge where Q moved, and per-edge strobe/busy masks.
  task automatic run_const(input logic din, input int n, output int q_edge,
                           output logic [31:0] rise_mask, output logic [31:0] fall_mask,
                           output logic [31:0] busy_mask);
    exp_t ob;
    logic q0;
    q0        = Q;
    q_edge    = 0;
    rise_mask = '0;
    fall_mask = '0;
    busy_mask = '0;
    for (int i = 1; i <= n; i++) begin
      cycle(din, ob);
      if (ob.q != q0 && q_edge == 0) q_edge = i;
      if (ob.rise) rise_mask[i] = 1'b1;
      if (ob.fall) fall_mask[i] = 1'b1;
      if (ob.busy) busy_mask[i] = 1'b1;
    end
  endtask

  initial begin
    // 1. Reset with D_IN high: outputs clear with no clock edge, then rise after 6 edges.
    RST  = 1'b1;
    D_IN = 1'b1;
    model_reset();
    #2;
    check_eq("reset_outputs", 32'({Q, RISE, FALL, BUSY}), 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    run_const(1'b1, 8, qe, rm, fm, bm);
    check_eq("rst_release_q_edge", 32'(qe), 32'd6);
    check_eq("rst_release_rise", rm, 32'h40);

    // 2. Clean fall then clean rise/fall with BUSY on edges 3..5.
    run_const(1'b0, 8, qe, rm, fm, bm);
    check_eq("fall_q_edge", 32'(qe), 32'd6);
    check_eq("fall_strobe", fm, 32'h40);
    run_const(1'b1, 8, qe, rm, fm, bm);
    check_eq("rise_q_edge", 32'(qe), 32'd6);
    check_eq("rise_strobe", rm, 32'h40);
    check_eq("rise_busy", bm, 32'h38);
    check_eq("rise_no_fall", fm, 32'h0);
    run_const(1'b0, 8, qe, rm, fm, bm);
    check_eq("fall2_q_edge", 32'(qe), 32'd6);
    check_eq("fall2_busy", bm, 32'h38);

    // 3. Bounce 1,0,1,0 then held high: Q moves on edge 6 of the hold, one RISE.
    rt0 = rise_total;
    cycle(1'b1, o);
    cycle(1'b0, o);
    cycle(1'b1, o);
    cycle(1'b0, o);
    run_const(1'b1, 8, qe, rm, fm, bm);
    check_eq("bounce_q_edge", 32'(qe), 32'd6);
    check_eq("bounce_rise", rm, 32'h40);
    check_eq("bounce_rise_count", 32'(rise_total - rt0), 32'd1);
    run_const(1'b0, 8, qe, rm, fm, bm);
    check_eq("bounce_fall_q_edge", 32'(qe), 32'd6);

    // 4. Three-cycle pulse is rejected.
    run_const(1'b1, 3, qe, rm, fm, bm);
    check_eq("pulse_busy_a", bm, 32'h08);
    check_eq("pulse_q_a", 32'(qe), 32'd0);
    run_const(1'b0, 8, qe, rm, fm, bm);
    check_eq("pulse_busy_b", bm, 32'h06);
    check_eq("pulse_q_b", 32'(qe), 32'd0);
    check_eq("pulse_rise", rm, 32'h0);
    check_eq("pulse_busy_end", 32'(BUSY), 32'd0);

    // Toggle every cycle: Q frozen, BUSY toggles.
    rt0 = rise_total;
    bm  = '0;
    for (int i = 1; i <= 10; i++) begin
      cycle(i[0], o);
      if (o.busy) bm[i] = 1'b1;
      check_eq("toggle_q", 32'(o.q), 32'd0);
    end
    check_eq("toggle_busy", bm, 32'h2A8);
    check_eq("toggle_rise_count", 32'(rise_total - rt0), 32'd0);
    run_const(1'b0, 6, qe, rm, fm, bm);

    // 5. Reset while qualifying with counter at 2.
    run_const(1'b1, 4, qe, rm, fm, bm);
    check_eq("midrst_busy_pre", bm, 32'h18);
    check_eq("midrst_busy_now", 32'(BUSY), 32'd1);
    RST = 1'b1;
    model_reset();
    #1;
    check_eq("midrst_outputs", 32'({Q, RISE, FALL, BUSY}), 32'h0);
    #2;
    RST = 1'b0;
    run_const(1'b1, 8, qe, rm, fm, bm);
    check_eq("midrst_q_edge", 32'(qe), 32'd6);
    check_eq("midrst_rise", rm, 32'h40);
    check_eq("midrst_busy", bm, 32'h38);

    // Async reset while Q is high.
    check_eq("prerst_q", 32'(Q), 32'd1);
    RST = 1'b1;
    model_reset();
    #1;
    check_eq("rst_q_high", 32'({Q, RISE, FALL, BUSY}), 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    D_IN = 1'b0;

    // 6. 257 clean rise/fall cycles; event counter wraps to 1.
`ifdef DEBOUNCE_EVENT_CNT_EN
    check_eq("evcnt_reset", 32'(EVENT_CNT), 32'd0);
`endif
    rt0 = rise_total;
    for (int k = 0; k < 257; k++) begin
      run_const(1'b1, 7, qe, rm, fm, bm);
      check_eq("loop_rise_edge", 32'(qe), 32'd6);
      run_const(1'b0, 7, qe, rm, fm, bm);
      check_eq("loop_fall_edge", 32'(qe), 32'd6);
    end
    check_eq("loop_rise_count", 32'(rise_total - rt0), 32'd257);
`ifdef DEBOUNCE_EVENT_CNT_EN
    check_eq("evcnt_wrap", 32'(EVENT_CNT), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
